// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES-128 key schedule.
// Streams round keys 0..NR over a valid/ready handshake, one new key per
// accepted transfer. Optional 11-entry round-key table under AES_KEY_TABLE_EN.
module aes_key_expand #(
    parameter int unsigned NR = 10  // only 10 (AES-128) is legal
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [127:0] i_key,
    output logic         o_busy,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [127:0] o_rkey,
    output logic [3:0]   o_round,
    output logic         o_done,
    input  logic [3:0]   i_rd_idx,
    output logic [127:0] o_rd_key,
    output logic         o_tbl_valid
);

    typedef enum logic [1:0] {
        IDLE,
        OUT,
        DONE
    } state_t;

    // Standard AES forward S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd0:    rc = 8'h01;
            4'd1:    rc = 8'h02;
            4'd2:    rc = 8'h04;
            4'd3:    rc = 8'h08;
            4'd4:    rc = 8'h10;
            4'd5:    rc = 8'h20;
            4'd6:    rc = 8'h40;
            4'd7:    rc = 8'h80;
            4'd8:    rc = 8'h1b;
            4'd9:    rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    state_t       state_q, state_d;
    logic [127:0] rkey_q, rkey_d;
    logic [3:0]   round_q, round_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic         xfer;
    logic         start_acc;
    logic         last_xfer;
    logic [31:0]  w0, w1, w2, w3, t, n0, n1, n2, n3;
    logic [127:0] next_key;

    assign xfer      = valid_q & i_ready;
    assign start_acc = (state_q == IDLE) & i_start;
    assign last_xfer = (state_q == OUT) & xfer & (round_q == 4'(NR));

    // Next round key from the current one: one g() step plus XOR chain.
    always_comb begin
        w0 = rkey_q[127:96];
        w1 = rkey_q[95:64];
        w2 = rkey_q[63:32];
        w3 = rkey_q[31:0];
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(round_q), 24'h0};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    // Next-state and next-output logic for the IDLE/OUT/DONE sequencer.
    always_comb begin
        state_d = state_q;
        rkey_d  = rkey_q;
        round_d = round_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    rkey_d  = i_key;
                    round_d = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (xfer) begin
                    if (round_q == 4'(NR)) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        rkey_d  = next_key;
                        round_d = round_q + 4'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            rkey_q  <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rkey_q  <= rkey_d;
            round_q <= round_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_rkey  = rkey_q;
    assign o_round = round_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

`ifdef AES_KEY_TABLE_EN
    logic [127:0] key_tbl [0:10];
    logic         tbl_valid_q;

    // Capture each transferred key at its round index.
    always_ff @(posedge i_clk) begin
        if (xfer && (state_q == OUT)) begin
            key_tbl[round_q] <= rkey_q;
        end
    end

    // Table-complete flag: set with the done pulse, cleared by a new start.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tbl_valid_q <= 1'b0;
        end else if (start_acc) begin
            tbl_valid_q <= 1'b0;
        end else if (last_xfer) begin
            tbl_valid_q <= 1'b1;
        end
    end

    assign o_rd_key    = (i_rd_idx <= 4'd10) ? key_tbl[i_rd_idx] : '0;
    assign o_tbl_valid = tbl_valid_q;
`else
    logic unused_tbl;
    assign unused_tbl  = ^{i_rd_idx, start_acc, last_xfer};
    assign o_rd_key    = '0;
    assign o_tbl_valid = 1'b0;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: randomized self-checking bench for aes_key_expand.
// Reference schedule is built from GF(2^8) arithmetic (S-box derived from
// multiplicative inverse + affine map) and the word-wise FIPS-197 recurrence.
module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         valid;
    logic         ready;
    logic [127:0] rkey;
    logic [3:0]   round;
    logic         done;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
    logic         tbl_valid;

    int checks = 0;
    int errors = 0;

`ifdef AES_KEY_TABLE_EN
    localparam bit TBL_EN = 1'b1;
`else
    localparam bit TBL_EN = 1'b0;
`endif

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;

    aes_key_expand #(.NR(10)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_key      (key),
        .o_busy     (busy),
        .o_valid    (valid),
        .i_ready    (ready),
        .o_rkey     (rkey),
        .o_round    (round),
        .o_done     (done),
        .i_rd_idx   (rd_idx),
        .o_rd_key   (rd_key),
        .o_tbl_valid(tbl_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [7:0]   ref_sbox [0:255];
    logic [127:0] ref_keys [0:10];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        if (a == 8'h00) return 8'h00;
        for (int i = 0; i < 254; i++) r = gmul(r, a);
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] b;
        for (int i = 0; i < 256; i++) begin
            b = ginv(8'(i));
            ref_sbox[i] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
        end
    endtask

    task automatic build_ref(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {ref_sbox[t[31:24]], ref_sbox[t[23:16]], ref_sbox[t[15:8]], ref_sbox[t[7:0]]}
                    ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) ref_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_key(input logic [127:0] k);
        start = 1'b1;
        key   = k;
        tick();
        start = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; ready = 1'b0; key = '0; rd_idx = '0;
        tick(); tick();
        checks++;
        if ({busy, valid, rkey, round, done, tbl_valid} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b valid=%b rkey=%h round=%0d done=%b tbl=%b exp all 0",
                     busy, valid, rkey, round, done, tbl_valid);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fips();
        build_ref(FIPS_KEY);
        ready = 1'b1;
        start_key(FIPS_KEY);
        for (int r = 0; r <= 10; r++) begin
            checks++;
            if (valid !== 1'b1 || busy !== 1'b1 || round !== 4'(r) || rkey !== ref_keys[r]) begin
                errors++;
                $display("FAIL fips_stream r=%0d got v=%b b=%b round=%0d rkey=%h exp v=1 b=1 round=%0d rkey=%h",
                         r, valid, busy, round, rkey, r, ref_keys[r]);
            end
            if (r == 1) begin
                checks++;
                if (rkey !== FIPS_R1) begin
                    errors++;
                    $display("FAIL fips_r1 got %h exp %h", rkey, FIPS_R1);
                end
            end
            if (r == 10) begin
                checks++;
                if (rkey !== FIPS_R10) begin
                    errors++;
                    $display("FAIL fips_r10 got %h exp %h", rkey, FIPS_R10);
                end
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b0 || tbl_valid !== TBL_EN) begin
            errors++;
            $display("FAIL fips_done got done=%b valid=%b busy=%b tbl=%b exp done=1 valid=0 busy=0 tbl=%b",
                     done, valid, busy, tbl_valid, TBL_EN);
        end
        tick();
        checks++;
        if (done !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL fips_done_pulse got done=%b valid=%b exp done=0 valid=0", done, valid);
        end
    endtask

    task automatic test_table();
        rd_idx = 4'd10;
        #1;
        checks++;
        if (rd_key !== (TBL_EN ? FIPS_R10 : 128'h0) || tbl_valid !== TBL_EN) begin
            errors++;
            $display("FAIL tbl_idx10 got %h tbl=%b exp %h tbl=%b", rd_key, tbl_valid,
                     TBL_EN ? FIPS_R10 : 128'h0, TBL_EN);
        end
        rd_idx = 4'd12;
        #1;
        checks++;
        if (rd_key !== 128'h0) begin
            errors++;
            $display("FAIL tbl_idx12 got %h exp 0", rd_key);
        end
        for (int i = 0; i <= 10; i++) begin
            rd_idx = 4'(i);
            #1;
            checks++;
            if (rd_key !== (TBL_EN ? ref_keys[i] : 128'h0)) begin
                errors++;
                $display("FAIL tbl_read idx=%0d got %h exp %h", i, rd_key,
                         TBL_EN ? ref_keys[i] : 128'h0);
            end
        end
        rd_idx = '0;
    endtask

    task automatic test_backpressure();
        logic [127:0] k;
        k = rand_key();
        build_ref(k);
        ready = 1'b1;
        start_key(k);
        for (int r = 0; r <= 10; r++) begin
            checks++;
            if (valid !== 1'b1 || round !== 4'(r) || rkey !== ref_keys[r]) begin
                errors++;
                $display("FAIL bp_stream r=%0d got v=%b round=%0d rkey=%h exp rkey=%h",
                         r, valid, round, rkey, ref_keys[r]);
            end
            if (r == 3) begin
                ready = 1'b0;
                repeat (5) begin
                    tick();
                    checks++;
                    if (valid !== 1'b1 || round !== 4'd3 || rkey !== ref_keys[3]) begin
                        errors++;
                        $display("FAIL bp_hold got v=%b round=%0d rkey=%h exp v=1 round=3 rkey=%h",
                                 valid, round, rkey, ref_keys[3]);
                    end
                end
                ready = 1'b1;
            end
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL bp_done got %b exp 1", done);
        end
        tick();
    endtask

    task automatic test_start_while_busy();
        logic [127:0] k;
        k = rand_key();
        build_ref(k);
        ready = 1'b1;
        start_key(k);
        for (int r = 0; r <= 10; r++) begin
            checks++;
            if (valid !== 1'b1 || round !== 4'(r) || rkey !== ref_keys[r]) begin
                errors++;
                $display("FAIL busy_start r=%0d got v=%b round=%0d rkey=%h exp rkey=%h",
                         r, valid, round, rkey, ref_keys[r]);
            end
            start = (r == 5);
            key   = (r == 5) ? 128'h0 : k;
            tick();
        end
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_done got done=%b valid=%b exp done=1 valid=0", done, valid);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [127:0] k;
        k = rand_key();
        build_ref(k);
        ready = 1'b1;
        start_key(k);
        repeat (7) tick();
        checks++;
        if (round !== 4'd7 || rkey !== ref_keys[7]) begin
            errors++;
            $display("FAIL rstmid_pre got round=%0d rkey=%h exp round=7 rkey=%h", round, rkey, ref_keys[7]);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({busy, valid, rkey, round, done, tbl_valid} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs got busy=%b valid=%b rkey=%h round=%0d done=%b exp all 0",
                     busy, valid, rkey, round, done);
        end
        rst = 1'b0;
        build_ref(128'h0);
        start_key(128'h0);
        for (int r = 0; r <= 10; r++) begin
            checks++;
            if (valid !== 1'b1 || round !== 4'(r) || rkey !== ref_keys[r]) begin
                errors++;
                $display("FAIL zero_key r=%0d got v=%b round=%0d rkey=%h exp rkey=%h",
                         r, valid, round, rkey, ref_keys[r]);
            end
            if (r == 1) begin
                checks++;
                if (rkey !== ZERO_R1) begin
                    errors++;
                    $display("FAIL zero_r1 got %h exp %h", rkey, ZERO_R1);
                end
            end
            tick();
        end
        tick();
    endtask

    task automatic test_random_ready();
        logic [127:0] k;
        int  r;
        int  cycles;
        bit  finished;
        bit  rdy;
        for (int n = 0; n < 4; n++) begin
            k = rand_key();
            build_ref(k);
            start_key(k);
            r = 0;
            cycles = 0;
            finished = 1'b0;
            while (!finished && cycles < 300) begin
                rdy = 1'($urandom_range(0, 1));
                ready = rdy;
                checks++;
                if (valid !== 1'b1 || round !== 4'(r) || rkey !== ref_keys[r]) begin
                    errors++;
                    $display("FAIL rand_stream n=%0d r=%0d got v=%b round=%0d rkey=%h exp rkey=%h",
                             n, r, valid, round, rkey, ref_keys[r]);
                end
                tick();
                cycles++;
                if (rdy) begin
                    if (r == 10) finished = 1'b1;
                    else r++;
                end
            end
            checks++;
            if (!finished || done !== 1'b1) begin
                errors++;
                $display("FAIL rand_done n=%0d got finished=%b done=%b exp 1 1", n, finished, done);
            end
            ready = 1'b1;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] k1;
        logic [127:0] k2;
        k1 = rand_key();
        k2 = rand_key();
        build_ref(k1);
        ready = 1'b1;
        start_key(k1);
        repeat (10) tick();
        checks++;
        if (round !== 4'd10 || rkey !== ref_keys[10]) begin
            errors++;
            $display("FAIL b2b_r10 got round=%0d rkey=%h exp %h", round, rkey, ref_keys[10]);
        end
        start = 1'b1;
        key   = k2;
        tick();
        checks++;
        if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b0 || tbl_valid !== TBL_EN) begin
            errors++;
            $display("FAIL b2b_final_ignore got done=%b valid=%b busy=%b tbl=%b exp 1 0 0 %b",
                     done, valid, busy, tbl_valid, TBL_EN);
        end
        tick();
        checks++;
        if (done !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_ignore got done=%b valid=%b busy=%b exp 0 0 0", done, valid, busy);
        end
        tick();
        start = 1'b0;
        build_ref(k2);
        checks++;
        if (valid !== 1'b1 || busy !== 1'b1 || round !== 4'd0 || rkey !== k2 || tbl_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_restart got v=%b b=%b round=%0d rkey=%h tbl=%b exp 1 1 0 %h 0",
                     valid, busy, round, rkey, tbl_valid, k2);
        end
        for (int r = 0; r <= 10; r++) begin
            checks++;
            if (valid !== 1'b1 || round !== 4'(r) || rkey !== ref_keys[r]) begin
                errors++;
                $display("FAIL b2b_stream r=%0d got round=%0d rkey=%h exp %h", r, round, rkey, ref_keys[r]);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done got %b exp 1", done);
        end
        tick();
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips();
        test_table();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid();
        test_random_ready();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
